// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller:
// forward-select codes and memory-wait FSM states.
package pipeline_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stall/flush/forward out.
// master = pipeline side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 32
);

  logic [NUM_SRC*REG_AW-1:0] rs_d;
  logic [NUM_SRC*REG_AW-1:0] rs_e;
  logic [REG_AW-1:0]         rd_e;
  logic [REG_AW-1:0]         rd_m;
  logic [REG_AW-1:0]         rd_w;
  logic                      regwrite_m;
  logic                      regwrite_w;
  logic                      load_e;
  logic                      pcsrc_e;
  logic                      mem_req_m;
  logic                      mem_ack_m;

  logic [NUM_SRC*2-1:0]      forward_e;
  logic                      stall_f;
  logic                      stall_d;
  logic                      stall_e;
  logic                      stall_m;
  logic                      flush_d;
  logic                      flush_e;
  logic                      flush_w;
  logic                      mem_err;
  logic [CNT_W-1:0]          stall_cnt;
  logic [CNT_W-1:0]          flush_cnt;
  logic [CNT_W-1:0]          memwait_cnt;

  modport master (
    output rs_d, rs_e, rd_e, rd_m, rd_w,
    output regwrite_m, regwrite_w,
    output load_e, pcsrc_e,
    output mem_req_m, mem_ack_m,
    input  forward_e,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_w,
    input  mem_err,
    input  stall_cnt, flush_cnt, memwait_cnt
  );

  modport slave (
    input  rs_d, rs_e, rd_e, rd_m, rd_w,
    input  regwrite_m, regwrite_w,
    input  load_e, pcsrc_e,
    input  mem_req_m, mem_ack_m,
    output forward_e,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_w,
    output mem_err,
    output stall_cnt, flush_cnt, memwait_cnt
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Forward select for one E-stage source operand.
// M-stage result wins over W; x0 is never forwarded.
module hazard_fwd_sel
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  output logic [1:0]        sel
);

  logic m_hit;
  logic w_hit;

  assign m_hit = regwrite_m && (rd_m != '0) && (rd_m == rs);
  assign w_hit = regwrite_w && (rd_w != '0) && (rd_w == rs);

  always_comb begin
    sel = FWD_NONE;
    if (m_hit) begin
      sel = FWD_M;
    end else if (w_hit) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit: forwarding, load-use/branch control, memory-wait FSM.
// Define HAZARD_PERF_EN to build the saturating performance counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int WCW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  mem_state_e           state;
  mem_state_e           state_nx;
  logic [WCW-1:0]       wcnt;
  logic                 timeout;
  logic                 mem_busy;
  logic                 lu_hit;
  logic [NUM_SRC-1:0]   rs_hit;
  logic [NUM_SRC*2-1:0] fwd;

  logic sf, sd, se, sm;
  logic fd, fe, fw;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    hazard_fwd_sel #(
      .REG_AW(REG_AW)
    ) u_sel (
      .rs        (hz.rs_e[i*REG_AW +: REG_AW]),
      .rd_m      (hz.rd_m),
      .rd_w      (hz.rd_w),
      .regwrite_m(hz.regwrite_m),
      .regwrite_w(hz.regwrite_w),
      .sel       (fwd[i*2 +: 2])
    );
    assign rs_hit[i] = (hz.rs_d[i*REG_AW +: REG_AW] == hz.rd_e);
  end

  assign lu_hit = hz.load_e && (hz.rd_e != '0) && (|rs_hit);

  assign timeout  = (state == WAIT) && (wcnt == WCW'(TIMEOUT));
  assign mem_busy = ((state == IDLE) && hz.mem_req_m && !hz.mem_ack_m) ||
                    ((state == WAIT) && !hz.mem_ack_m && !timeout);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      if ((state == WAIT) && (state_nx == WAIT)) begin
        wcnt <= wcnt + WCW'(1);
      end else begin
        wcnt <= '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (hz.mem_req_m && !hz.mem_ack_m) state_nx = WAIT;
      WAIT: if (hz.mem_ack_m || timeout) state_nx = IDLE;
    endcase
  end

  // A pending memory access freezes the whole pipe and masks branch/load-use.
  always_comb begin
    sf = 1'b0;
    sd = 1'b0;
    se = 1'b0;
    sm = 1'b0;
    fd = 1'b0;
    fe = 1'b0;
    fw = 1'b0;
    if (mem_busy) begin
      sf = 1'b1;
      sd = 1'b1;
      se = 1'b1;
      sm = 1'b1;
      fw = 1'b1;
    end else begin
      fd = hz.pcsrc_e;
      fe = hz.pcsrc_e || lu_hit;
      sf = lu_hit && !hz.pcsrc_e;
      sd = lu_hit && !hz.pcsrc_e;
    end
  end

  assign hz.forward_e = rst ? fwd : '0;
  assign hz.stall_f   = rst && sf;
  assign hz.stall_d   = rst && sd;
  assign hz.stall_e   = rst && se;
  assign hz.stall_m   = rst && sm;
  assign hz.flush_d   = rst && fd;
  assign hz.flush_e   = rst && fe;
  assign hz.flush_w   = rst && fw;
  assign hz.mem_err   = rst && timeout && !hz.mem_ack_m;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] memwait_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q   <= '0;
      flush_q   <= '0;
      memwait_q <= '0;
    end else begin
      if (sf && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (fd && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
      if (mem_busy && !(&memwait_q)) memwait_q <= memwait_q + CNT_W'(1);
    end
  end

  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;
  assign hz.memwait_cnt = memwait_q;
`else
  assign hz.stall_cnt   = CNT_W'(0);
  assign hz.flush_cnt   = CNT_W'(0);
  assign hz.memwait_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (TIMEOUT=4, CNT_W=4).
// Counter expectations follow HAZARD_PERF_EN.
module tb_pipeline_hazard_ctrl;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int TO = 4;
  localparam int CW = 4;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ctl bit order: sf sd se sm fd fe fw err
  localparam logic [7:0] C_NONE = 8'h00;
  localparam logic [7:0] C_BUSY = 8'hF2;
  localparam logic [7:0] C_LU   = 8'hC4;
  localparam logic [7:0] C_BR   = 8'h0C;
  localparam logic [7:0] C_ERR  = 8'h01;

  typedef struct packed {
    logic       wm;
    logic [4:0] rdm;
    logic       ww;
    logic [4:0] rdw;
    logic [9:0] rse;
    logic [3:0] exp;
  } fv_t;

  localparam fv_t FV [7] = '{
    '{1'b1, 5'd5, 1'b1, 5'd5, {5'd3, 5'd5}, 4'b0010},
    '{1'b1, 5'd0, 1'b1, 5'd5, {5'd3, 5'd5}, 4'b0001},
    '{1'b1, 5'd5, 1'b1, 5'd5, {5'd5, 5'd5}, 4'b1010},
    '{1'b0, 5'd5, 1'b1, 5'd5, {5'd5, 5'd5}, 4'b0101},
    '{1'b1, 5'd0, 1'b1, 5'd0, {5'd0, 5'd0}, 4'b0000},
    '{1'b1, 5'd3, 1'b1, 5'd5, {5'd3, 5'd5}, 4'b1001},
    '{1'b0, 5'd5, 1'b0, 5'd5, {5'd5, 5'd5}, 4'b0000}
  };

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if #(
    .REG_AW(AW), .NUM_SRC(NS), .CNT_W(CW)
  ) hz ();

  pipeline_hazard_ctrl #(
    .REG_AW(AW), .NUM_SRC(NS), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  logic [7:0] ctl;
  assign ctl = {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
                hz.flush_d, hz.flush_e, hz.flush_w, hz.mem_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_in();
    hz.rs_d       = '0;
    hz.rs_e       = '0;
    hz.rd_e       = '0;
    hz.rd_m       = '0;
    hz.rd_w       = '0;
    hz.regwrite_m = 1'b0;
    hz.regwrite_w = 1'b0;
    hz.load_e     = 1'b0;
    hz.pcsrc_e    = 1'b0;
    hz.mem_req_m  = 1'b0;
    hz.mem_ack_m  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_in();
    step();
    step();
    rst = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    hz.regwrite_m = 1'b1;
    hz.rd_m       = 5'd5;
    hz.rs_e       = {5'd5, 5'd5};
    hz.load_e     = 1'b1;
    hz.rd_e       = 5'd7;
    hz.rs_d       = {5'd7, 5'd7};
    hz.pcsrc_e    = 1'b1;
    hz.mem_req_m  = 1'b1;
    hz.mem_ack_m  = 1'b0;
    step();
    step();
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL reset_ctl got %b want %b", ctl, C_NONE);
    end
    checks++;
    if (hz.forward_e !== 4'b0000) begin
      errors++;
      $display("FAIL reset_fwd got %b want 0000", hz.forward_e);
    end
    checks++;
    if ({hz.stall_cnt, hz.flush_cnt, hz.memwait_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL reset_cnt got %h want 000",
               {hz.stall_cnt, hz.flush_cnt, hz.memwait_cnt});
    end
    idle_in();
    rst = 1'b1;
    settle();
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL post_reset_ctl got %b want %b", ctl, C_NONE);
    end
  endtask

  task automatic test_forward();
    for (int i = 0; i < 7; i++) begin
      hz.regwrite_m = FV[i].wm;
      hz.rd_m       = FV[i].rdm;
      hz.regwrite_w = FV[i].ww;
      hz.rd_w       = FV[i].rdw;
      hz.rs_e       = FV[i].rse;
      settle();
      checks++;
      if (hz.forward_e !== FV[i].exp) begin
        errors++;
        $display("FAIL fwd_vec%0d got %b want %b", i, hz.forward_e, FV[i].exp);
      end
    end
    idle_in();
  endtask

  task automatic test_load_use();
    step();
    hz.load_e = 1'b1;
    hz.rd_e   = 5'd7;
    hz.rs_d   = {5'd7, 5'd2};
    settle();
    checks++;
    if (ctl !== C_LU) begin
      errors++;
      $display("FAIL lu_slot1 got %b want %b", ctl, C_LU);
    end
    step();
    hz.load_e = 1'b0;
    settle();
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL lu_release got %b want %b", ctl, C_NONE);
    end
    hz.load_e = 1'b1;
    hz.rd_e   = 5'd0;
    hz.rs_d   = {5'd0, 5'd0};
    settle();
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL lu_x0 got %b want %b", ctl, C_NONE);
    end
    hz.rd_e = 5'd9;
    hz.rs_d = {5'd3, 5'd9};
    settle();
    checks++;
    if (ctl !== C_LU) begin
      errors++;
      $display("FAIL lu_slot0 got %b want %b", ctl, C_LU);
    end
    hz.rd_e    = 5'd7;
    hz.rs_d    = {5'd7, 5'd2};
    hz.pcsrc_e = 1'b1;
    settle();
    checks++;
    if (ctl !== C_BR) begin
      errors++;
      $display("FAIL lu_branch got %b want %b", ctl, C_BR);
    end
    hz.load_e = 1'b0;
    settle();
    checks++;
    if (ctl !== C_BR) begin
      errors++;
      $display("FAIL branch_only got %b want %b", ctl, C_BR);
    end
    idle_in();
  endtask

  task automatic test_memwait();
    do_reset();
    hz.mem_req_m = 1'b1;
    hz.mem_ack_m = 1'b0;
    settle();
    checks++;
    if (ctl !== C_BUSY) begin
      errors++;
      $display("FAIL mw_c0 got %b want %b", ctl, C_BUSY);
    end
    step();
    hz.pcsrc_e = 1'b1;
    hz.load_e  = 1'b1;
    hz.rd_e    = 5'd7;
    hz.rs_d    = {5'd7, 5'd2};
    settle();
    checks++;
    if (ctl !== C_BUSY) begin
      errors++;
      $display("FAIL mw_c1_masked got %b want %b", ctl, C_BUSY);
    end
    step();
    hz.pcsrc_e = 1'b0;
    hz.load_e  = 1'b0;
    settle();
    checks++;
    if (ctl !== C_BUSY) begin
      errors++;
      $display("FAIL mw_c2 got %b want %b", ctl, C_BUSY);
    end
    step();
    hz.mem_ack_m = 1'b1;
    settle();
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL mw_ack got %b want %b", ctl, C_NONE);
    end
    step();
    hz.mem_req_m = 1'b0;
    hz.mem_ack_m = 1'b0;
    settle();
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL mw_after got %b want %b", ctl, C_NONE);
    end
    checks++;
    if (hz.memwait_cnt !== (PERF ? 4'd3 : 4'd0)) begin
      errors++;
      $display("FAIL mw_cnt got %0d want %0d", hz.memwait_cnt, PERF ? 3 : 0);
    end
    checks++;
    if ({hz.stall_cnt, hz.flush_cnt} !== (PERF ? 8'h30 : 8'h00)) begin
      errors++;
      $display("FAIL mw_sf_cnt got %h want %h",
               {hz.stall_cnt, hz.flush_cnt}, PERF ? 8'h30 : 8'h00);
    end
    hz.mem_req_m = 1'b1;
    hz.mem_ack_m = 1'b1;
    settle();
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL zero_wait got %b want %b", ctl, C_NONE);
    end
    step();
    hz.mem_req_m = 1'b0;
    hz.mem_ack_m = 1'b0;
    settle();
    checks++;
    if (ctl !== C_NONE || hz.memwait_cnt !== (PERF ? 4'd3 : 4'd0)) begin
      errors++;
      $display("FAIL zero_wait_after got %b/%0d want %b/%0d",
               ctl, hz.memwait_cnt, C_NONE, PERF ? 3 : 0);
    end
  endtask

  task automatic test_timeout();
    int  n;
    bit  done;
    do_reset();
    hz.mem_req_m = 1'b1;
    hz.mem_ack_m = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
      checks++;
      if (ctl !== ((k < 5) ? C_BUSY : C_ERR)) begin
        errors++;
        $display("FAIL to_cyc%0d got %b want %b",
                 k, ctl, (k < 5) ? C_BUSY : C_ERR);
      end
      step();
    end
    hz.mem_req_m = 1'b0;
    settle();
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL to_idle got %b want %b", ctl, C_NONE);
    end
    checks++;
    if (hz.memwait_cnt !== (PERF ? 4'd5 : 4'd0)) begin
      errors++;
      $display("FAIL to_cnt got %0d want %0d", hz.memwait_cnt, PERF ? 5 : 0);
    end
    step();
    hz.mem_req_m = 1'b1;
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      settle();
      if (ctl === C_BUSY) n++;
      else if (ctl === C_ERR) done = 1'b1;
      step();
    end
    checks++;
    if (!done || n != 5) begin
      errors++;
      $display("FAIL to_rerun got done=%0d busy=%0d want done=1 busy=5",
               done, n);
    end
    idle_in();
    step();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    hz.mem_req_m = 1'b1;
    hz.mem_ack_m = 1'b0;
    step();
    step();
    hz.regwrite_m = 1'b1;
    hz.rd_m       = 5'd5;
    hz.rs_e       = {5'd5, 5'd5};
    settle();
    checks++;
    if (ctl !== C_BUSY) begin
      errors++;
      $display("FAIL rw_pre got %b want %b", ctl, C_BUSY);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NONE || hz.forward_e !== 4'b0000) begin
      errors++;
      $display("FAIL rw_async got %b/%b want %b/0000",
               ctl, hz.forward_e, C_NONE);
    end
    checks++;
    if ({hz.stall_cnt, hz.flush_cnt, hz.memwait_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL rw_cnt got %h want 000",
               {hz.stall_cnt, hz.flush_cnt, hz.memwait_cnt});
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (ctl !== C_NONE) begin
        errors++;
        $display("FAIL rw_hold%0d got %b want %b", k, ctl, C_NONE);
      end
    end
    idle_in();
    rst = 1'b1;
    settle();
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL rw_idle got %b want %b", ctl, C_NONE);
    end
    step();
  endtask

  task automatic test_counter_sat();
    do_reset();
    hz.load_e = 1'b1;
    hz.rd_e   = 5'd7;
    hz.rs_d   = {5'd7, 5'd2};
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) begin
        checks++;
        if (hz.stall_cnt !== (PERF ? 4'd10 : 4'd0)) begin
          errors++;
          $display("FAIL sat_mid got %0d want %0d",
                   hz.stall_cnt, PERF ? 10 : 0);
        end
      end
    end
    checks++;
    if (hz.stall_cnt !== (PERF ? 4'd15 : 4'd0)) begin
      errors++;
      $display("FAIL sat_stall got %0d want %0d", hz.stall_cnt, PERF ? 15 : 0);
    end
    checks++;
    if (ctl !== C_LU || hz.flush_cnt !== 4'd0) begin
      errors++;
      $display("FAIL sat_state got %b/%0d want %b/0", ctl, hz.flush_cnt, C_LU);
    end
    idle_in();
    hz.pcsrc_e = 1'b1;
    step();
    step();
    step();
    hz.pcsrc_e = 1'b0;
    settle();
    checks++;
    if (hz.flush_cnt !== (PERF ? 4'd3 : 4'd0)) begin
      errors++;
      $display("FAIL flush_cnt got %0d want %0d", hz.flush_cnt, PERF ? 3 : 0);
    end
    checks++;
    if (hz.stall_cnt !== (PERF ? 4'd15 : 4'd0)) begin
      errors++;
      $display("FAIL sat_hold got %0d want %0d", hz.stall_cnt, PERF ? 15 : 0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle_in();
    test_reset();
    test_forward();
    test_load_use();
    test_memwait();
    test_timeout();
    test_reset_mid_wait();
    test_counter_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameters: REG_AW, default 5, register-address width; NUM_SRC, default 2, source operands per instruction (2..3); TIMEOUT, default 255, maximum memory-wait cycles; CNT_W, default 32, performance-counter width.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low.
- rs_d  in  NUM_SRC*REG_AW  Decode-stage source registers; slot i is bits [i*REG_AW +: REG_AW].
- rs_e  in  NUM_SRC*REG_AW  Execute-stage source registers.
- rd_e, rd_m, rd_w  in  REG_AW  destination registers in E, M, W.
- regwrite_m, regwrite_w  in  1  register-write enables in M, W.
- load_e  in  1  E-stage instruction is a load.
- pcsrc_e  in  1  branch/jump taken in E.
- mem_req_m  in  1  M-stage data-memory access.
- mem_ack_m  in  1  data memory completes this cycle.
- forward_e  out  NUM_SRC*2  per-slot forward select.
- stall_f, stall_d, stall_e, stall_m  out  1  hold stage register.
- flush_d, flush_e, flush_w  out  1  bubble into stage register.
- mem_err  out  1  one-cycle memory-timeout pulse.
- stall_cnt, flush_cnt, memwait_cnt  out  CNT_W  performance counters.

Function
REQ-003 Per slot i, forward_e SHALL be 2'b10 if regwrite_m, rd_m!=0 and rd_m==rs_e[i]; else 2'b01 if regwrite_w, rd_w!=0 and rd_w==rs_e[i]; else 2'b00 (M has priority).
REQ-004 Load-use: if load_e, rd_e!=0 and rd_e equals any rs_d slot, stall_f=stall_d=flush_e=1 in the same cycle.
REQ-005 Branch: pcsrc_e SHALL drive flush_d=flush_e=1 and suppress the load-use stall in the same cycle.
REQ-006 Memory-wait FSM states SHALL be IDLE and WAIT.
- IDLE->WAIT when mem_req_m && !mem_ack_m.
- WAIT->IDLE on mem_ack_m, or when the wait counter reaches TIMEOUT.
REQ-007 mem_busy = (IDLE && mem_req_m && !mem_ack_m) || (WAIT && !mem_ack_m && !timeout).
REQ-008 While mem_busy, outputs SHALL be stall_f=stall_d=stall_e=stall_m=1 and flush_w=1. All other stall/flush outputs SHALL be 0, and pcsrc_e and load-use SHALL be ignored until release.
REQ-009 Wait counter:
- cleared on entering WAIT; increments each WAIT cycle.
- on reaching TIMEOUT: mem_err=1 for exactly one cycle, FSM returns to IDLE, stalls deassert that cycle.
REQ-010 mem_ack_m arriving in IDLE with mem_req_m SHALL cause no stall (zero-wait access).
REQ-011 Stall and flush outputs SHALL be combinational from inputs and FSM state (zero-cycle latency). Only FSM state, the wait counter and the performance counters SHALL be registered.

Reset
REQ-012 While rst=0, the block SHALL hold FSM=IDLE, wait counter=0 and all counters=0, and SHALL force all outputs to 0, including forward_e.
REQ-013 Reset asserted during WAIT SHALL abort the wait immediately, with no mem_err pulse.

Configuration
REQ-014 With macro HAZARD_PERF_EN defined, the counters SHALL behave as follows, each saturating at all-ones:
- stall_cnt increments on cycles with stall_f=1.
- flush_cnt increments on cycles with flush_d=1.
- memwait_cnt increments on cycles with mem_busy=1.
REQ-015 Without HAZARD_PERF_EN, the three counter outputs SHALL be constant 0 and their registers SHALL be absent.

Structure
REQ-016 Shared package pipeline_pkg SHALL hold FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10 and the FSM state encoding IDLE/WAIT.
REQ-017 Sub-module hazard_fwd_sel SHALL compute one slot's forward select, instantiated NUM_SRC times by generate.

Verification
REQ-018 The bench SHALL cover:
- regwrite_m=1, rd_m=5, regwrite_w=1, rd_w=5, rs_e slot0=5 -> forward_e[1:0]=2'b10; rd_m=0 -> 2'b01.
- load_e=1, rd_e=7, rs_d slot1=7 -> stall_f=stall_d=flush_e=1 for one cycle; add pcsrc_e=1 -> stall_f=0, flush_d=flush_e=1.
- mem_req_m=1, mem_ack_m low 3 cycles then high -> stall_m=flush_w=1 for exactly 3 cycles; memwait_cnt=3 (HAZARD_PERF_EN).
- TIMEOUT=4, mem_ack_m never -> mem_err pulses once on the 5th busy-edge cycle; FSM returns to IDLE.
- rst=0 mid-WAIT -> all outputs 0 asynchronously, no mem_err; after release, state IDLE.
- counters with CNT_W=4 held in stall 20 cycles -> stall_cnt=15 (saturated); without macro -> 0.
